// File: rtl/id_ex_pipe_pkg.sv
// rtl/id_ex_pipe_pkg.sv - control-bundle typedef, bit positions and opcode constants for the ID/EX pipe
package id_ex_pipe_pkg;

  localparam int CTRL_W = 11;

  // Bit positions inside the packed bundle {ALUOp[2:0],RegDest,RegWrite,ALUSrc,MemRead,MemWrite,MemToReg,Branch,Jump}
  localparam int CTRL_JUMP      = 0;
  localparam int CTRL_BRANCH    = 1;
  localparam int CTRL_MEMTOREG  = 2;
  localparam int CTRL_MEMWRITE  = 3;
  localparam int CTRL_MEMREAD   = 4;
  localparam int CTRL_ALUSRC    = 5;
  localparam int CTRL_REGWRITE  = 6;
  localparam int CTRL_REGDEST   = 7;
  localparam int CTRL_ALUOP_LSB = 8;
  localparam int CTRL_ALUOP_W   = 3;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       reg_dest;
    logic       reg_write;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic       jump;
  } ctrl_t;

  localparam logic [2:0] ALUOP_ADD   = 3'd0;
  localparam logic [2:0] ALUOP_SUB   = 3'd1;
  localparam logic [2:0] ALUOP_RTYPE = 3'd2;
  localparam logic [2:0] ALUOP_AND   = 3'd3;
  localparam logic [2:0] ALUOP_OR    = 3'd4;
  localparam logic [2:0] ALUOP_SLT   = 3'd5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

  function automatic logic ctrl_is_load(input logic [CTRL_W-1:0] c);
    ctrl_t t;
    t = ctrl_t'(c);
    return t.mem_read;
  endfunction

endpackage

// File: rtl/id_ex_pipe_if.sv
// rtl/id_ex_pipe_if.sv - decode-side inputs and EX-stage outputs of the ID/EX pipe register
interface id_ex_pipe_if
  import id_ex_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic [CTRL_W-1:0] id_ctrl_i;
  logic [DATA_W-1:0] id_pc4_i;
  logic [DATA_W-1:0] id_rdata1_i;
  logic [DATA_W-1:0] id_rdata2_i;
  logic [DATA_W-1:0] id_imm_i;
  logic [REG_AW-1:0] id_rs_i;
  logic [REG_AW-1:0] id_rt_i;
  logic [REG_AW-1:0] id_rd_i;
  logic              flush_i;
  logic              stall_o;
  logic [CTRL_W-1:0] ex_ctrl_o;
  logic [DATA_W-1:0] ex_pc4_o;
  logic [DATA_W-1:0] ex_rdata1_o;
  logic [DATA_W-1:0] ex_rdata2_o;
  logic [DATA_W-1:0] ex_imm_o;
  logic [REG_AW-1:0] ex_rs_o;
  logic [REG_AW-1:0] ex_rt_o;
  logic [REG_AW-1:0] ex_rd_o;
  logic              ex_valid_o;
  logic [15:0]       bubble_cnt_o;

  // Decode stage (or bench) side
  modport master (
    output id_ctrl_i, id_pc4_i, id_rdata1_i, id_rdata2_i, id_imm_i,
    output id_rs_i, id_rt_i, id_rd_i, flush_i,
    input  stall_o, ex_ctrl_o, ex_pc4_o, ex_rdata1_o, ex_rdata2_o, ex_imm_o,
    input  ex_rs_o, ex_rt_o, ex_rd_o, ex_valid_o, bubble_cnt_o
  );

  // Pipe register side
  modport slave (
    input  id_ctrl_i, id_pc4_i, id_rdata1_i, id_rdata2_i, id_imm_i,
    input  id_rs_i, id_rt_i, id_rd_i, flush_i,
    output stall_o, ex_ctrl_o, ex_pc4_o, ex_rdata1_o, ex_rdata2_o, ex_imm_o,
    output ex_rs_o, ex_rt_o, ex_rd_o, ex_valid_o, bubble_cnt_o
  );
endinterface

// File: rtl/id_ex_pipe_hazard_detect.sv
// rtl/id_ex_pipe_hazard_detect.sv - combinational load-use hazard compare between EX load and ID sources
module hazard_detect #(
  parameter int REG_AW = 5
) (
  input  logic              i_ex_valid,
  input  logic              i_ex_mem_read,
  input  logic [REG_AW-1:0] i_ex_rt,
  input  logic [REG_AW-1:0] i_id_rs,
  input  logic [REG_AW-1:0] i_id_rt,
  output logic              o_hazard
);
  logic w_rt_nonzero;
  logic w_match;

  // $zero is never a real producer, so a load targeting it cannot create a dependency
  assign w_rt_nonzero = |i_ex_rt;
  assign w_match      = (i_ex_rt == i_id_rs) | (i_ex_rt == i_id_rt);
  assign o_hazard     = i_ex_valid & i_ex_mem_read & w_rt_nonzero & w_match;
endmodule

// File: rtl/id_ex_pipe.sv
// rtl/id_ex_pipe.sv - ID/EX pipeline register with bubble insertion; ID_EX_HAZARD_DETECT_EN enables load-use stall
module id_ex_pipe
  import id_ex_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic        clk,
  input  logic        rst,
  id_ex_pipe_if.slave bus
);
  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_pc4;
  logic [DATA_W-1:0] r_rdata1;
  logic [DATA_W-1:0] r_rdata2;
  logic [DATA_W-1:0] r_imm;
  logic [REG_AW-1:0] r_rs;
  logic [REG_AW-1:0] r_rt;
  logic [REG_AW-1:0] r_rd;
  logic              r_valid;
  logic [15:0]       r_bubble_cnt;
  logic              w_hazard;
  logic              w_bubble;

`ifdef ID_EX_HAZARD_DETECT_EN
  hazard_detect #(.REG_AW(REG_AW)) u_hazard_detect (
    .i_ex_valid    (r_valid),
    .i_ex_mem_read (ctrl_is_load(r_ctrl)),
    .i_ex_rt       (r_rt),
    .i_id_rs       (bus.id_rs_i),
    .i_id_rt       (bus.id_rt_i),
    .o_hazard      (w_hazard)
  );
`else
  assign w_hazard = 1'b0;
`endif

  // Flush kills the ID instruction anyway, so holding the front end would only waste a cycle
  assign w_bubble    = bus.flush_i | w_hazard;
  assign bus.stall_o = ~rst & ~bus.flush_i & w_hazard;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl       <= CTRL_BUBBLE;
      r_pc4        <= '0;
      r_rdata1     <= '0;
      r_rdata2     <= '0;
      r_imm        <= '0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_rd         <= '0;
      r_valid      <= 1'b0;
      r_bubble_cnt <= '0;
    end else if (w_bubble) begin
      r_ctrl   <= CTRL_BUBBLE;
      r_pc4    <= '0;
      r_rdata1 <= '0;
      r_rdata2 <= '0;
      r_imm    <= '0;
      r_rs     <= '0;
      r_rt     <= '0;
      r_rd     <= '0;
      r_valid  <= 1'b0;
      if (r_bubble_cnt != 16'hFFFF) begin
        r_bubble_cnt <= r_bubble_cnt + 16'd1;
      end
    end else begin
      r_ctrl   <= bus.id_ctrl_i;
      r_pc4    <= bus.id_pc4_i;
      r_rdata1 <= bus.id_rdata1_i;
      r_rdata2 <= bus.id_rdata2_i;
      r_imm    <= bus.id_imm_i;
      r_rs     <= bus.id_rs_i;
      r_rt     <= bus.id_rt_i;
      r_rd     <= bus.id_rd_i;
      r_valid  <= 1'b1;
    end
  end

  assign bus.ex_ctrl_o    = r_ctrl;
  assign bus.ex_pc4_o     = r_pc4;
  assign bus.ex_rdata1_o  = r_rdata1;
  assign bus.ex_rdata2_o  = r_rdata2;
  assign bus.ex_imm_o     = r_imm;
  assign bus.ex_rs_o      = r_rs;
  assign bus.ex_rt_o      = r_rt;
  assign bus.ex_rd_o      = r_rd;
  assign bus.ex_valid_o   = r_valid;
  assign bus.bubble_cnt_o = r_bubble_cnt;
endmodule

// File: tb/tb_id_ex_pipe.sv
// tb/tb_id_ex_pipe.sv - directed self-checking bench for id_ex_pipe (both ID_EX_HAZARD_DETECT_EN builds)
module tb_id_ex_pipe;
`ifdef ID_EX_HAZARD_DETECT_EN
  localparam int HAZ = 1;
`else
  localparam int HAZ = 0;
`endif

  localparam logic [10:0] C_ADDI = {3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [10:0] C_LW   = {3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam logic [10:0] C_ADD  = {3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  id_ex_pipe_if #(.DATA_W(32), .REG_AW(5)) bus ();

  id_ex_pipe #(.DATA_W(32), .REG_AW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [10:0] ctrl, input logic [31:0] pc4, input logic [31:0] rd1,
                       input logic [31:0] rd2, input logic [31:0] imm, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input logic flush);
    bus.id_ctrl_i   = ctrl;
    bus.id_pc4_i    = pc4;
    bus.id_rdata1_i = rd1;
    bus.id_rdata2_i = rd2;
    bus.id_imm_i    = imm;
    bus.id_rs_i     = rs;
    bus.id_rt_i     = rt;
    bus.id_rd_i     = rd;
    bus.flush_i     = flush;
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    // Reset with noisy inputs and a flush pending
    drive(C_LW, 32'hDEAD, 32'h1, 32'h2, 32'h3, 5'd1, 5'd2, 5'd3, 1'b1);
    chk("rst_stall", 64'(bus.stall_o), 64'd0);
    tick();
    chk("rst_ctrl", 64'(bus.ex_ctrl_o), 64'd0);
    chk("rst_valid", 64'(bus.ex_valid_o), 64'd0);
    chk("rst_cnt", 64'(bus.bubble_cnt_o), 64'd0);
    chk("rst_pc4", 64'(bus.ex_pc4_o), 64'd0);
    rst = 1'b0;

    // addi with negative immediate
    drive(C_ADDI, 32'h104, 32'h10, 32'h55, 32'hFFFF_FFFC, 5'd9, 5'd10, 5'd0, 1'b0);
    chk("addi_stall", 64'(bus.stall_o), 64'd0);
    tick();
    chk("addi_imm", 64'(bus.ex_imm_o), 64'hFFFF_FFFC);
    chk("addi_rdata1", 64'(bus.ex_rdata1_o), 64'h10);
    chk("addi_ctrl", 64'(bus.ex_ctrl_o), 64'(C_ADDI));
    chk("addi_valid", 64'(bus.ex_valid_o), 64'd1);
    chk("addi_pc4", 64'(bus.ex_pc4_o), 64'h104);
    chk("addi_rt", 64'(bus.ex_rt_o), 64'd10);

    // lw $t0 then dependent add
    drive(C_LW, 32'h108, 32'h1000, 32'h0, 32'h4, 5'd29, 5'd8, 5'd0, 1'b0);
    chk("lw_stall", 64'(bus.stall_o), 64'd0);
    tick();
    chk("lw_rt", 64'(bus.ex_rt_o), 64'd8);
    drive(C_ADD, 32'h10C, 32'h7, 32'h9, 32'h0, 5'd8, 5'd9, 5'd10, 1'b0);
    chk("lu_stall", 64'(bus.stall_o), 64'(HAZ));
    tick();
    chk("lu_valid", 64'(bus.ex_valid_o), 64'(1 - HAZ));
    chk("lu_ctrl", 64'(bus.ex_ctrl_o), (HAZ != 0) ? 64'd0 : 64'(C_ADD));
    chk("lu_cnt", 64'(bus.bubble_cnt_o), 64'(HAZ));
    chk("lu_hold_stall", 64'(bus.stall_o), 64'd0);
    tick();
    chk("lu_add_valid", 64'(bus.ex_valid_o), 64'd1);
    chk("lu_add_rd", 64'(bus.ex_rd_o), 64'd10);
    chk("lu_add_ctrl", 64'(bus.ex_ctrl_o), 64'(C_ADD));

    // lw to $zero never stalls
    drive(C_LW, 32'h110, 32'h0, 32'h0, 32'h8, 5'd4, 5'd0, 5'd0, 1'b0);
    tick();
    drive(C_ADD, 32'h114, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd11, 1'b0);
    chk("zero_stall", 64'(bus.stall_o), 64'd0);
    tick();
    chk("zero_valid", 64'(bus.ex_valid_o), 64'd1);
    chk("zero_rd", 64'(bus.ex_rd_o), 64'd11);
    chk("zero_cnt", 64'(bus.bubble_cnt_o), 64'(HAZ));

    // Hazard and flush together: one bubble, no stall
    drive(C_LW, 32'h118, 32'h0, 32'h0, 32'h0, 5'd4, 5'd8, 5'd0, 1'b0);
    tick();
    drive(C_ADD, 32'h11C, 32'hAB, 32'hCD, 32'h0, 5'd1, 5'd8, 5'd12, 1'b1);
    chk("fl_stall", 64'(bus.stall_o), 64'd0);
    tick();
    chk("fl_valid", 64'(bus.ex_valid_o), 64'd0);
    chk("fl_ctrl", 64'(bus.ex_ctrl_o), 64'd0);
    chk("fl_rdata1", 64'(bus.ex_rdata1_o), 64'd0);
    chk("fl_cnt", 64'(bus.bubble_cnt_o), 64'(HAZ + 1));

    // NOP behind a load to $t0 passes as valid without stalling
    drive(C_LW, 32'h120, 32'h0, 32'h0, 32'h0, 5'd4, 5'd8, 5'd0, 1'b0);
    tick();
    drive(11'd0, 32'h124, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0);
    chk("nop_stall", 64'(bus.stall_o), 64'd0);
    tick();
    chk("nop_valid", 64'(bus.ex_valid_o), 64'd1);
    chk("nop_ctrl", 64'(bus.ex_ctrl_o), 64'd0);

    // Back-to-back dependent loads: a single stall cycle per load
    drive(C_LW, 32'h128, 32'h0, 32'h0, 32'h0, 5'd4, 5'd5, 5'd0, 1'b0);
    tick();
    drive(C_LW, 32'h12C, 32'h0, 32'h0, 32'h0, 5'd5, 5'd6, 5'd0, 1'b0);
    chk("b2b_stall1", 64'(bus.stall_o), 64'(HAZ));
    tick();
    chk("b2b_cnt", 64'(bus.bubble_cnt_o), 64'(2 * HAZ + 1));
    chk("b2b_stall2", 64'(bus.stall_o), 64'd0);
    tick();
    chk("b2b_valid", 64'(bus.ex_valid_o), 64'd1);
    chk("b2b_rt", 64'(bus.ex_rt_o), 64'd6);

    // Reset in the middle of a stall
    drive(C_ADD, 32'h130, 32'h3, 32'h4, 32'h0, 5'd6, 5'd2, 5'd13, 1'b0);
    chk("rs_pre_stall", 64'(bus.stall_o), 64'(HAZ));
    rst = 1'b1;
    #1;
    chk("rs_stall", 64'(bus.stall_o), 64'd0);
    tick();
    chk("rs_valid", 64'(bus.ex_valid_o), 64'd0);
    chk("rs_ctrl", 64'(bus.ex_ctrl_o), 64'd0);
    chk("rs_rt", 64'(bus.ex_rt_o), 64'd0);
    chk("rs_cnt", 64'(bus.bubble_cnt_o), 64'd0);
    rst = 1'b0;
    #1;
    chk("rs_post_stall", 64'(bus.stall_o), 64'd0);
    tick();
    chk("rs_post_valid", 64'(bus.ex_valid_o), 64'd1);
    chk("rs_post_rs", 64'(bus.ex_rs_o), 64'd6);
    chk("rs_post_rdata1", 64'(bus.ex_rdata1_o), 64'h3);

    // Counter saturation
    drive(C_ADD, 32'h134, 32'h0, 32'h0, 32'h0, 5'd1, 5'd2, 5'd3, 1'b1);
    for (int i = 0; i < 65535; i++) begin
      tick();
    end
    chk("sat_full", 64'(bus.bubble_cnt_o), 64'hFFFF);
    tick();
    chk("sat_hold", 64'(bus.bubble_cnt_o), 64'hFFFF);
    chk("sat_valid", 64'(bus.ex_valid_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/id_ex_pipe.md
ID_EX_PIPE -- requirements
Module: id_ex_pipe

Interface
REQ-001 SHALL have parameter DATA_W, 32, datapath width.
REQ-002 SHALL have parameter REG_AW, 5, register-index width.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port id_ctrl_i  in  11  packed control bundle {ALUOp[2:0],RegDest,RegWrite,ALUSrc,MemRead,MemWrite,MemToReg,Branch,Jump} from decode control.
REQ-006 SHALL have ports id_pc4_i, id_rdata1_i, id_rdata2_i, id_imm_i  in  DATA_W  PC+4, register-file reads, sign-extended immediate.
REQ-007 SHALL have ports id_rs_i, id_rt_i, id_rd_i  in  REG_AW  decoded register indices.
REQ-008 SHALL have port flush_i  in  1  kill the instruction in ID (taken branch/jump).
REQ-009 SHALL have port stall_o  out  1  hold PC and IF/ID this cycle.
REQ-010 SHALL have ports ex_ctrl_o (11), ex_pc4_o, ex_rdata1_o, ex_rdata2_o, ex_imm_o (DATA_W), ex_rs_o, ex_rt_o, ex_rd_o (REG_AW)  out  registered EX-stage copies.
REQ-011 SHALL have port ex_valid_o  out  1  EX slot holds a real instruction.
REQ-012 SHALL have port bubble_cnt_o  out  16  count of inserted bubbles.

Function
REQ-013 Normal cycle: all ex_* outputs SHALL register the id_* inputs with exactly one cycle latency; ex_valid_o=1.
REQ-014 Load-use hazard SHALL be detected combinationally when ex_valid_o=1, ex_ctrl_o.MemRead=1, ex_rt_o!=0, and ex_rt_o equals id_rs_i or id_rt_i.
REQ-015 On hazard (flush_i=0): stall_o=1 same cycle; next edge loads a bubble.
REQ-016 Bubble: ex_ctrl_o all zero, ex_valid_o=0; datapath fields SHALL load zero.
REQ-017 flush_i=1 SHALL load a bubble at the next edge and force stall_o=0 (flush has priority over hazard).
REQ-018 Each bubble load (hazard or flush) SHALL increment bubble_cnt_o by 1; counter saturates at 16'hFFFF.
REQ-019 An all-zero id_ctrl_i with id_rs_i=id_rt_i=id_rd_i=0 (NOP) SHALL pass as valid but never trigger a hazard.
REQ-020 Back-to-back loads: stall_o SHALL assert for at most one consecutive cycle per load (bubble clears MemRead).

Reset
REQ-021 rst=1 at an edge SHALL zero every ex_* output, ex_valid_o and bubble_cnt_o, overriding flush/hazard; stall_o=0 while rst=1.
REQ-022 Reset asserted mid-stall SHALL discard the stall; first post-reset edge loads id_* normally.

Configuration
REQ-023 Macro ID_EX_HAZARD_DETECT_EN defined: REQ-014/015 active.
REQ-024 Macro undefined: stall_o tied 0, no hazard logic; bubbles only via flush_i, counter counts flushes only.

Structure
REQ-025 Package SHALL hold control-bundle typedef, bit-position constants, opcode constants, CTRL_W=11.
REQ-026 Sub-module hazard_detect (combinational compare, excluded when macro undefined) SHALL be used.

Verification
REQ-027 lw $t0 in EX (rt=8, MemRead=1), ID add rs=8 -> stall_o=1, next cycle ex_valid_o=0, ex_ctrl_o=0, bubble_cnt_o=1.
REQ-028 lw rt=0 in EX, ID rs=0 -> stall_o=0, ID instruction registers normally.
REQ-029 Hazard and flush_i=1 same cycle -> stall_o=0, one bubble, bubble_cnt_o+=1 only once.
REQ-030 addi id_imm_i=32'hFFFF_FFFC, rdata1=32'h10 -> next cycle ex_imm_o=32'hFFFF_FFFC, ex_rdata1_o=32'h10, ex_ctrl_o ALUSrc=1, RegWrite=1.
REQ-031 Preload bubble_cnt_o=16'hFFFF via 65535 flushes, one more flush -> stays 16'hFFFF.
REQ-032 rst=1 during hazard stall -> all outputs zero next edge; rst=0 -> next instruction passes with ex_valid_o=1.
